// File: rtl/anim_pkg.sv
// Shared types and constants for the animation frame sequencer.
//   state_t : sequencer states (IDLE, RUN, DONE)
//   mode_t  : playback mode codes as presented on the mode input
package anim_pkg;

  localparam int unsigned FRAME_W          = 5;
  localparam int unsigned PRESC_W          = 24;
  localparam int unsigned BASE_DIV_DEFAULT = 12500000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_LOOP     = 2'd0,
    MODE_PINGPONG = 2'd1,
    MODE_ONESHOT  = 2'd2,
    MODE_LOOP_ALT = 2'd3   // behaves as loop
  } mode_t;

endpackage

// File: rtl/anim_prescaler.sv
// Frame-period prescaler: counts 0..period-1 while enabled, wraps, and
// flags the terminal count combinationally so the owner can act on that edge.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to 0 (wins over en)
//   en         : advance the count this cycle
//   period     : cycles per wrap (>= 1)
//   term_c     : high in the cycle the count sits at period-1 while enabled
module anim_prescaler
  import anim_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [PRESC_W-1:0] period,
  output logic               term_c
);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;
  logic               at_end;

  assign at_end = (cnt_q == (period - PRESC_W'(1)));
  assign term_c = en && !clr && at_end;

  // Next count: clear, wrap at terminal, or increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_end ? '0 : cnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/anim_frame_seq.sv
// Animation frame sequencer: steps a 5-bit frame index at a programmable
// rate in loop, ping-pong or one-shot order.
//   clk, rst_n : clock, async active-low reset
//   start      : begin playback from frame 0 (ignored while running)
//   stop       : halt playback, hold frame (wins over start)
//   mode       : 0 loop, 1 ping-pong, 2 one-shot, 3 loop; latched on start
//   speed      : period = BASE_DIV >> speed; latched on start
//   frame      : current frame index
//   running    : high while playing
//   tick       : one-cycle pulse per frame advance
//   done       : one-cycle pulse when one-shot playback completes
module anim_frame_seq
  import anim_pkg::*;
#(
  parameter int unsigned BASE_DIV   = BASE_DIV_DEFAULT,
  parameter int unsigned LAST_FRAME = 31
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [1:0]         speed,
  output logic [FRAME_W-1:0] frame,
  output logic               running,
  output logic               tick,
  output logic               done
);

  localparam logic [PRESC_W-1:0] BASE = PRESC_W'(BASE_DIV);
  localparam logic [FRAME_W-1:0] LAST = FRAME_W'(LAST_FRAME);

  state_t             state_q,   state_d;
  logic [FRAME_W-1:0] frame_q,   frame_d;
  logic               dir_dn_q,  dir_dn_d;
  mode_t              mode_q,    mode_d;
  logic [1:0]         speed_q,   speed_d;
  logic               tick_q,    tick_d;
  logic               done_q,    done_d;
  logic               running_q, running_d;

  logic               presc_clr;
  logic               presc_en;
  logic               term_c;
  logic [PRESC_W-1:0] period;

  assign period    = BASE >> speed_q;
  assign presc_en  = (state_q == ST_RUN);
  // Outside RUN the count is held at zero, so a new start always begins a full period.
  assign presc_clr = (state_q != ST_RUN) || stop;

  anim_prescaler u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (presc_clr),
    .en     (presc_en),
    .period (period),
    .term_c (term_c)
  );

  // Next-state, frame sequencing and output pulses.
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    dir_dn_d = dir_dn_q;
    mode_d   = mode_q;
    speed_d  = speed_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && !stop) begin
          state_d  = ST_RUN;
          frame_d  = '0;
          dir_dn_d = 1'b0;
          mode_d   = mode_t'(mode);
          speed_d  = speed;
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (term_c) begin
          case (mode_q)
            MODE_PINGPONG: begin
              tick_d = 1'b1;
              if (!dir_dn_q) begin
                if (frame_q == LAST) begin
                  frame_d  = LAST - FRAME_W'(1);
                  dir_dn_d = 1'b1;
                end else begin
                  frame_d = frame_q + FRAME_W'(1);
                end
              end else begin
                if (frame_q == '0) begin
                  frame_d  = FRAME_W'(1);
                  dir_dn_d = 1'b0;
                end else begin
                  frame_d = frame_q - FRAME_W'(1);
                end
              end
            end
            MODE_ONESHOT: begin
              // Advancing past the last frame ends playback instead of ticking.
              if (frame_q == LAST) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                frame_d = frame_q + FRAME_W'(1);
                tick_d  = 1'b1;
              end
            end
            default: begin
              tick_d  = 1'b1;
              frame_d = (frame_q == LAST) ? '0 : frame_q + FRAME_W'(1);
            end
          endcase
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      dir_dn_q  <= 1'b0;
      mode_q    <= MODE_LOOP;
      speed_q   <= 2'd0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      dir_dn_q  <= dir_dn_d;
      mode_q    <= mode_d;
      speed_q   <= speed_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  assign frame   = frame_q;
  assign running = running_q;
  assign tick    = tick_q;
  assign done    = done_q;

endmodule

// File: tb/tb_anim_frame_seq.sv
// Self-checking bench for anim_frame_seq (BASE_DIV=8, LAST_FRAME=31).
// Reference model: playback position is derived from the number of cycles
// elapsed since the accepted start; the frame is a closed-form function of
// the advance count for each mode.
module tb_anim_frame_seq;

  localparam int unsigned BASE = 8;
  localparam int unsigned LAST = 31;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [1:0] speed;
  logic [4:0] frame;
  logic       running;
  logic       tick;
  logic       done;

  int n_checks;
  int n_fail;

  // Model state
  bit          m_run;
  int unsigned m_mode;
  int unsigned m_speed;
  int unsigned m_c;
  int unsigned m_frame;
  bit          e_tick;
  bit          e_done;

  anim_frame_seq #(.BASE_DIV(BASE), .LAST_FRAME(LAST)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .mode    (mode),
    .speed   (speed),
    .frame   (frame),
    .running (running),
    .tick    (tick),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Frame shown after k advances since start, for a given mode.
  function automatic int unsigned seq_frame(input int unsigned md, input int unsigned k);
    int unsigned r;
    case (md)
      1: begin
        r = k % (2 * LAST);
        return (r <= LAST) ? r : (2 * LAST - r);
      end
      2: return k;
      default: return k % (LAST + 1);
    endcase
  endfunction

  task automatic model_reset();
    m_run = 0; m_mode = 0; m_speed = 0; m_c = 0; m_frame = 0;
    e_tick = 0; e_done = 0;
  endtask

  task automatic model_edge(input bit s, input bit p, input int unsigned md, input int unsigned sp);
    int unsigned per;
    int unsigned k;
    e_tick = 0;
    e_done = 0;
    if (m_run) begin
      if (p) begin
        m_run = 0;
      end else begin
        m_c++;
        per = BASE >> m_speed;
        if (m_c % per == 0) begin
          k = m_c / per;
          if (m_mode == 2 && k > LAST) begin
            m_run  = 0;
            e_done = 1;
          end else begin
            m_frame = seq_frame(m_mode, k);
            e_tick  = 1;
          end
        end
      end
    end else if (s && !p) begin
      m_run = 1; m_c = 0; m_frame = 0; m_mode = md; m_speed = sp;
    end
  endtask

  task automatic check_outputs();
    check_eq("frame",   32'(frame),   32'(m_frame));
    check_eq("running", 32'(running), 32'(m_run));
    check_eq("tick",    32'(tick),    32'(e_tick));
    check_eq("done",    32'(done),    32'(e_done));
  endtask

  // One clock: drive inputs, model the edge, sample 1 time unit later.
  task automatic step(input bit s, input bit p, input logic [1:0] md, input logic [1:0] sp);
    start = s; stop = p; mode = md; speed = sp;
    @(posedge clk);
    model_edge(s, p, 32'(md), 32'(sp));
    #1;
    check_outputs();
  endtask

  // Idle cycles with mode/speed inputs scrambled (must not disturb a run).
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
  endtask

  task automatic do_reset_async();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_frame",   32'(frame),   32'd0);
    check_eq("rst_running", 32'(running), 32'd0);
    check_eq("rst_tick",    32'(tick),    32'd0);
    check_eq("rst_done",    32'(done),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0; speed = 2'd0;
    #12;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 2'd0, 2'd0);

    // Loop at speed 0, including mid-run mode/speed noise and ignored restarts.
    step(1'b1, 1'b0, 2'd0, 2'd0);
    run_cycles(100);
    step(1'b1, 1'b0, 2'd2, 2'd3);
    run_cycles(180);
    step(1'b0, 1'b1, 2'd0, 2'd0);
    run_cycles(5);

    // Ping-pong at speed 1 through both endpoints.
    step(1'b1, 1'b0, 2'd1, 2'd1);
    run_cycles(2 * 62 * 4 + 10);
    step(1'b0, 1'b1, 2'd0, 2'd0);

    // One-shot completion, then restart from DONE.
    step(1'b1, 1'b0, 2'd2, 2'd0);
    run_cycles(32 * 8 + 12);
    check_eq("oneshot_frame_end", 32'(frame), 32'(LAST));
    step(1'b1, 1'b0, 2'd2, 2'd0);
    check_eq("oneshot_restart_frame", 32'(frame), 32'd0);
    check_eq("oneshot_restart_run",   32'(running), 32'd1);
    run_cycles(20);
    step(1'b0, 1'b1, 2'd0, 2'd0);

    // start+stop together at the prescaler terminal, then in IDLE.
    step(1'b1, 1'b0, 2'd0, 2'd0);
    run_cycles(20);
    for (int i = 0; i < 16 && ((m_c + 1) % (BASE >> m_speed)) != 0; i++) begin
      step(1'b0, 1'b0, 2'd0, 2'd0);
    end
    check_eq("at_terminal", 32'(((m_c + 1) % (BASE >> m_speed)) == 0), 32'd1);
    step(1'b1, 1'b1, 2'd0, 2'd0);
    step(1'b1, 1'b1, 2'd0, 2'd0);
    run_cycles(10);

    // Async reset during RUN at frame 17, then no activity until start.
    step(1'b1, 1'b0, 2'd3, 2'd0);
    for (int i = 0; i < 400 && m_frame != 17; i++) begin
      step(1'b0, 1'b0, 2'd3, 2'd0);
    end
    check_eq("reached_17", 32'(frame), 32'd17);
    do_reset_async();
    run_cycles(30);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 199) == 0),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 1999) == 0) do_reset_async();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/anim_frame_seq.md
ANIM_FRAME_SEQ -- requirements
Module: anim_frame_seq

Interface
REQ-001 Parameter BASE_DIV, default 12500000: clk cycles per frame at speed 0; legal range 8..2^24-1.
REQ-002 Parameter LAST_FRAME, default 31: highest frame index emitted; legal range 1..31.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  level; sampled each cycle; begins playback from frame 0.
REQ-006 stop  input  1  level; sampled each cycle; halts playback and holds the current frame.
REQ-007 mode  input  2  0 loop, 1 ping-pong, 2 one-shot, 3 treated as loop; latched on accepted start.
REQ-008 speed  input  2  frame period = BASE_DIV >> speed cycles; latched on accepted start.
REQ-009 frame  output  5  current frame index; drives the 7-segment pattern decoders directly.
REQ-010 running  output  1  high while in RUN.
REQ-011 tick  output  1  one-cycle pulse on every frame advance.
REQ-012 done  output  1  one-cycle pulse when one-shot playback completes.

Function
REQ-013 States SHALL be IDLE, RUN, DONE; running = (state == RUN); all outputs registered.
REQ-014 IDLE or DONE with start=1 and stop=0: next state RUN, frame <= 0, direction <= up, prescaler <= 0, mode/speed latched.
REQ-015 start while already in RUN SHALL be ignored (no restart, no re-latch).
REQ-016 RUN with stop=1: next state IDLE, frame held, prescaler cleared, no tick; stop SHALL win over simultaneous start and over a coincident prescaler terminal count.
REQ-017 Prescaler counts 0..P-1 (P = BASE_DIV >> latched speed) only in RUN; at P-1 it wraps to 0 and tick=1 the following cycle, with frame updated in that same cycle.
REQ-018 First frame advance occurs exactly P cycles after the cycle in which start is sampled.
REQ-019 Loop: frame increments; LAST_FRAME wraps to 0.
REQ-020 Ping-pong: up-direction at LAST_FRAME steps to LAST_FRAME-1 and sets down; down-direction at 0 steps to 1 and sets up; endpoints are shown for exactly one period each.
REQ-021 One-shot: increments; an advance that would leave LAST_FRAME instead enters DONE, frame stays LAST_FRAME, done=1 for that one cycle, no tick.
REQ-022 In IDLE and DONE, frame SHALL hold and tick SHALL remain 0.
REQ-023 frame SHALL never exceed LAST_FRAME; arithmetic on frame is 5-bit unsigned; prescaler width is 24 bits.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, frame 0, direction up, prescaler 0, running 0, tick 0, done 0, latched mode 0, latched speed 0.
REQ-025 Reset asserted mid-playback SHALL abandon playback; after release the block waits for a new start.

Structure
REQ-026 State encoding, mode codes and the default BASE_DIV constant SHALL live in a shared package anim_pkg.
REQ-027 The prescaler SHALL be one sub-module anim_prescaler (inputs clk, rst_n, clr, en, period; output terminal pulse); the state machine and frame counter stay in the top.

Verification (BASE_DIV=8, LAST_FRAME=31)
REQ-028 Loop, speed 0: start pulse -> tick every 8 cycles, frame 0,1,...,31,0; first tick 8 cycles after start.
REQ-029 Ping-pong, speed 1 (P=4): frame ...30,31,30,...,1,0,1; 31 and 0 each held 4 cycles; tick every 4 cycles.
REQ-030 One-shot, speed 0: after 32 periods -> done pulse of 1 cycle, frame=31, running=0, no further ticks; new start -> frame 0, running=1.
REQ-031 start and stop high together in RUN at prescaler terminal -> IDLE, frame unchanged, tick=0; same in IDLE -> stays IDLE.
REQ-032 rst_n low mid-RUN at frame 17 -> frame=0, running=0 asynchronously; no tick after release until start.
REQ-033 Mode/speed changed during RUN -> period and sequence unchanged until the next accepted start.
